// File: rtl/pl_rv32_mem_arbiter_if.sv
// pl_rv32_mem_arbiter_if: fetch, data and memory bus signals shared by the arbiter and its environment
interface pl_rv32_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err, dm_gnt, dm_rvalid, dm_rdata, dm_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );
  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err, dm_gnt, dm_rvalid, dm_rdata, dm_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );
endinterface

// File: rtl/pl_rv32_mem_arbiter.sv
// pl_rv32_mem_arbiter: shares one memory bus between fetch and data ports; optional fetch starvation guard via PL_MEM_ARB_STARVE_GUARD_EN
module pl_rv32_mem_arbiter #(
  parameter int TIMEOUT = 64
`ifdef PL_MEM_ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input logic clk,
  input logic rst,
  pl_rv32_mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam int CW = $clog2(TIMEOUT);
  state_t        r_state;
  logic          r_owner;
  logic [CW-1:0] r_cnt;
  logic w_force, w_sel_dm, w_sel_req, w_req, w_gnt, w_ok, w_to, w_rv, w_any;
`ifdef PL_MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1) > 3 ? $clog2(STARVE_LIMIT + 1) : 3;
  logic [SW-1:0] r_starve;
  assign w_force = bus.if_req && r_starve == SW'(STARVE_LIMIT);
`else
  assign w_force = 1'b0;
`endif
  assign w_any     = bus.if_req || bus.dm_req;
  assign w_sel_dm  = r_state == IDLE ? bus.dm_req && !w_force : r_owner;
  assign w_sel_req = w_sel_dm ? bus.dm_req : bus.if_req;
  assign w_req     = !rst && r_state != WAIT && w_sel_req;
  assign w_gnt     = w_req && bus.mem_gnt;
  assign w_ok      = r_state == WAIT && bus.mem_rvalid;
  assign w_to      = r_state == WAIT && !bus.mem_rvalid && r_cnt == CW'(TIMEOUT - 1);
  assign w_rv      = w_ok || w_to;
  assign bus.mem_req   = w_req;
  assign bus.mem_we    = w_req && w_sel_dm && bus.dm_we;
  assign bus.mem_addr  = !w_req ? '0 : w_sel_dm ? bus.dm_addr : bus.if_addr;
  assign bus.mem_wdata = w_req && w_sel_dm ? bus.dm_wdata : '0;
  assign bus.mem_wstrb = !w_req ? '0 : w_sel_dm ? bus.dm_wstrb : 4'hF;
  assign bus.if_gnt    = w_gnt && !w_sel_dm;
  assign bus.dm_gnt    = w_gnt && w_sel_dm;
  assign bus.if_rvalid = w_rv && !r_owner;
  assign bus.dm_rvalid = w_rv && r_owner;
  assign bus.if_err    = w_to && !r_owner;
  assign bus.dm_err    = w_to && r_owner;
  assign bus.if_rdata  = w_ok && !r_owner ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = w_ok && r_owner ? bus.mem_rdata : '0;
  assign bus.busy      = r_state != IDLE;
  // arbitration, owner lock and outstanding-response timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_owner <= w_sel_dm;
          r_cnt   <= '0;
          r_state <= bus.mem_gnt ? WAIT : REQ;
        end
        REQ: if (!w_sel_req) r_state <= IDLE;
          else if (bus.mem_gnt) begin
            r_state <= WAIT;
            r_cnt   <= '0;
          end
        WAIT: if (w_rv) r_state <= IDLE;
          else r_cnt <= r_cnt + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef PL_MEM_ARB_STARVE_GUARD_EN
  // count data wins over a waiting fetch; clears whenever fetch wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_starve <= '0;
    else if (r_state == IDLE && w_any)
      r_starve <= !w_sel_dm ? '0 : bus.if_req ? r_starve + 1'b1 : r_starve;
  end
`endif
endmodule
